// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: default widths, requester
// indices and the round-robin pointer width helper.
package wb_arbiter_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LSU  = 1;
  localparam int REQ_MDU  = 2;

  // A single requester still needs a one-bit pointer to keep vectors legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: the first valid requester at or after
// ptr_i (wrapping) gets a one-hot grant and its encoded index.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW:0] cand_s;
  logic        found_s;

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand_s >= (PW+1)'(NREQ)) begin
        cand_s = cand_s - (PW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && valid_i[cand_s[PW-1:0]]) begin
        found_s                   = 1'b1;
        grant_o[cand_s[PW-1:0]]   = 1'b1;
        idx_o                     = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file write port, plus a
// pending-write scoreboard that flags read-after-write hazards to issue.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_wa,
  input  logic [NREQ*DW-1:0] req_wd,
  output logic             reg_w_en,
  output logic [AW-1:0]    reg_wa_c,
  output logic [DW-1:0]    reg_wd_c,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    hz_ra_a,
  input  logic [AW-1:0]    hz_ra_b,
  output logic             hz_a,
  output logic             hz_b,
  output logic             sb_idle
);

  localparam int PW   = ptr_width(NREQ);
  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] gnt_s;
  logic [PW-1:0]   gnt_idx_s;
  logic            gnt_any_s;
  logic [AW-1:0]   gnt_wa_s;
  logic [DW-1:0]   gnt_wd_s;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            w_en_q, w_en_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic            idle_q, idle_d;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_s),
    .idx_o   (gnt_idx_s),
    .any_o   (gnt_any_s)
  );

  assign req_ready = gnt_s;

  // Select the granted requester's address and data (grant is one-hot).
  always_comb begin
    gnt_wa_s = '0;
    gnt_wd_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        gnt_wa_s = gnt_wa_s | req_wa[i*AW +: AW];
        gnt_wd_s = gnt_wd_s | req_wd[i*DW +: DW];
      end else begin
        gnt_wa_s = gnt_wa_s;
      end
    end
  end

  // Next-state: pointer, output register and scoreboard (set beats clear).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    w_en_d   = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    busy_d   = busy_q;
    if (gnt_any_s) begin
      rr_ptr_d = (gnt_idx_s == PW'(NREQ-1)) ? '0 : gnt_idx_s + PW'(1);
      w_en_d   = (gnt_wa_s != '0);
      wa_d     = gnt_wa_s;
      wd_d     = gnt_wd_s;
      busy_d[gnt_wa_s] = 1'b0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (iss_en && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d[iss_rd] = busy_d[iss_rd];
    end
    busy_d[0] = 1'b0;
    idle_d    = (busy_d == '0);
  end

  // State registers; reset drops any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      w_en_q   <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
      idle_q   <= 1'b1;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= w_en_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      idle_q   <= idle_d;
    end
  end

  assign reg_w_en = w_en_q;
  assign reg_wa_c = wa_q;
  assign reg_wd_c = wd_q;
  assign sb_idle  = idle_q;
  assign hz_a     = (hz_ra_a != '0) && busy_q[hz_ra_a];
  assign hz_b     = (hz_ra_b != '0) && busy_q[hz_ra_b];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares each write.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_wa = '0;
  logic [NREQ*DW-1:0] req_wd = '0;
  logic              reg_w_en;
  logic [AW-1:0]     reg_wa_c;
  logic [DW-1:0]     reg_wd_c;
  logic              iss_en = 1'b0;
  logic [AW-1:0]     iss_rd = '0;
  logic [AW-1:0]     hz_ra_a = '0;
  logic [AW-1:0]     hz_ra_b = '0;
  logic              hz_a, hz_b, sb_idle;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;
  int  rr_seq[6]   = '{1, 2, 0, 1, 2, 0};
  int  drop_seq[4] = '{2, 0, 2, 0};
  logic [DW-1:0] d_s;

  always #5 clk = ~clk;

  wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wa    (req_wa),
    .req_wd    (req_wd),
    .reg_w_en  (reg_w_en),
    .reg_wa_c  (reg_wa_c),
    .reg_wd_c  (reg_wd_c),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .hz_ra_a   (hz_ra_a),
    .hz_ra_b   (hz_ra_b),
    .hz_a      (hz_a),
    .hz_b      (hz_b),
    .sb_idle   (sb_idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    req_wa[i*AW +: AW] = wa;
    req_wd[i*DW +: DW] = wd;
  endtask

  task automatic expect_wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reg_w_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got wa=%0d wd=%h expected no write", reg_wa_c, reg_wd_c);
      end else begin
        mon_e = exp_q.pop_front();
        if (reg_wa_c !== mon_e.wa || reg_wd_c !== mon_e.wd) begin
          failures++;
          $display("FAIL write_port: got wa=%0d wd=%h expected wa=%0d wd=%h",
                   reg_wa_c, reg_wd_c, mon_e.wa, mon_e.wd);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    req_valid = 3'b110; hz_ra_a = 5'd5;
    #1;
    chk("rst_w_en", reg_w_en, 64'd0);
    chk("rst_wa", reg_wa_c, 64'd0);
    chk("rst_wd", reg_wd_c, 64'd0);
    chk("rst_idle", sb_idle, 64'd1);
    chk("rst_ready", req_ready, 64'b010);
    @(negedge clk); req_valid = '0; rst_n = 1'b1;

    // single write with a pending hazard on x5
    @(negedge clk); iss_en = 1'b1; iss_rd = 5'd5;
    #1 chk("t1_hz_same_cycle", hz_a, 64'd0);
    @(negedge clk); iss_en = 1'b0; req_valid = 3'b001; set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("t1_hz_pending", hz_a, 64'd1);
    chk("t1_idle_busy", sb_idle, 64'd0);
    chk("t1_ready", req_ready, 64'b001);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk); req_valid = '0;
    #1;
    chk("t1_w_en", reg_w_en, 64'd1);
    chk("t1_hz_cleared", hz_a, 64'd0);
    chk("t1_idle", sb_idle, 64'd1);

    // round-robin, all three valid (pointer starts at 1 after the ALU grant)
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = 3'b111;
      for (int i = 0; i < NREQ; i++) begin
        d_s = 32'hC000_0000 | (32'(i) << 8) | 32'(k);
        set_req(i, AW'(10 + i), d_s);
      end
      #1;
      chk("rr_ready", req_ready, 64'd1 << rr_seq[k]);
      if (k > 0) chk("rr_w_en", reg_w_en, 64'd1);
      expect_wr(AW'(10 + rr_seq[k]), 32'hC000_0000 | (32'(rr_seq[k]) << 8) | 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 3'b101;
      #1;
      chk("drop_ready", req_ready, 64'd1 << drop_seq[k]);
      expect_wr(AW'(10 + drop_seq[k]), 32'hC000_0000 | (32'(drop_seq[k]) << 8) | 32'd5);
    end

    // write to x0 is consumed without enabling the register file
    @(negedge clk); req_valid = 3'b010; set_req(REQ_LSU, 5'd0, 32'h0000_1234);
    iss_en = 1'b1; iss_rd = 5'd0;
    #1 chk("x0_ready", req_ready, 64'b010);
    @(negedge clk); req_valid = '0; iss_en = 1'b0; hz_ra_a = 5'd0;
    #1;
    chk("x0_w_en", reg_w_en, 64'd0);
    chk("x0_wa", reg_wa_c, 64'd0);
    chk("x0_wd", reg_wd_c, 64'h1234);
    chk("x0_hz", hz_a, 64'd0);
    chk("x0_idle", sb_idle, 64'd1);

    // set/clear collision on x7: set wins
    @(negedge clk); iss_en = 1'b1; iss_rd = 5'd7; hz_ra_a = 5'd7;
    @(negedge clk); iss_en = 1'b0;
    #1 chk("col_hz_set", hz_a, 64'd1);
    @(negedge clk); req_valid = 3'b100; set_req(REQ_MDU, 5'd7, 32'h0000_7777);
    iss_en = 1'b1; iss_rd = 5'd7;
    #1 chk("col_ready", req_ready, 64'b100);
    expect_wr(5'd7, 32'h0000_7777);
    @(negedge clk); req_valid = '0; iss_en = 1'b0;
    #1;
    chk("col_hz_kept", hz_a, 64'd1);
    chk("col_idle", sb_idle, 64'd0);
    @(negedge clk); req_valid = 3'b100; set_req(REQ_MDU, 5'd7, 32'h0000_7778);
    #1 chk("col2_ready", req_ready, 64'b100);
    expect_wr(5'd7, 32'h0000_7778);
    @(negedge clk); req_valid = '0;
    #1;
    chk("col2_hz", hz_a, 64'd0);
    chk("col2_idle", sb_idle, 64'd1);

    // async reset while a write is in flight with x5 and x7 busy
    @(negedge clk); iss_en = 1'b1; iss_rd = 5'd5;
    @(negedge clk); iss_rd = 5'd7;
    @(negedge clk); iss_en = 1'b0; req_valid = 3'b010; set_req(REQ_LSU, 5'd9, 32'h0000_0099);
    hz_ra_a = 5'd5; hz_ra_b = 5'd7;
    #1 chk("ar_ready", req_ready, 64'b010);
    @(posedge clk); #2;
    chk("ar_inflight", reg_w_en, 64'd1);
    chk("ar_hz_a", hz_a, 64'd1);
    chk("ar_hz_b", hz_b, 64'd1);
    rst_n = 1'b0; req_valid = 3'b110;
    #1;
    chk("ar_w_en", reg_w_en, 64'd0);
    chk("ar_wa", reg_wa_c, 64'd0);
    chk("ar_wd", reg_wd_c, 64'd0);
    chk("ar_hz_a0", hz_a, 64'd0);
    chk("ar_hz_b0", hz_b, 64'd0);
    chk("ar_idle", sb_idle, 64'd1);
    chk("ar_ptr_ready", req_ready, 64'b010);
    @(negedge clk); rst_n = 1'b1;
    set_req(REQ_LSU, 5'd3, 32'h0000_0033); set_req(REQ_MDU, 5'd4, 32'h0000_0044);
    #1 chk("ar_first_ready", req_ready, 64'b010);
    expect_wr(5'd3, 32'h0000_0033);
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    #1 chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
